// File: rtl/riscv_cache_biu_fill_if.sv
// BIU burst-read interface between the line-fill engine (master) and the bus
// interface unit (slave).
//   biu_req    master->slave  address phase request
//   biu_adr    master->slave  burst start address, XLEN-word aligned
//   biu_len    master->slave  burst length minus one
//   biu_ack    slave->master  address phase accepted
//   biu_d      slave->master  read data beat
//   biu_d_ack  slave->master  biu_d valid
//   biu_err    slave->master  bus error (address or data phase)
interface riscv_cache_biu_fill_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PLEN = 32
);
  logic            biu_req;
  logic [PLEN-1:0] biu_adr;
  logic [7:0]      biu_len;
  logic            biu_ack;
  logic [XLEN-1:0] biu_d;
  logic            biu_d_ack;
  logic            biu_err;

  modport master (
    output biu_req, biu_adr, biu_len,
    input  biu_ack, biu_d, biu_d_ack, biu_err
  );

  modport slave (
    input  biu_req, biu_adr, biu_len,
    output biu_ack, biu_d, biu_d_ack, biu_err
  );
endinterface

// File: rtl/riscv_cache_biu_fill.sv
// Cache line-fill engine. On a fill request it issues one wrapping burst that
// starts at the missed word, assembles the XLEN-wide beats into a BLK_BITS line,
// forwards the critical word early and pulses line_ack_o / line_err_o on
// completion / bus error.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   fill_req_i, fill_adr_i     fill request and miss byte address (IDLE only)
//   fill_busy_o                engine not idle
//   biu                        burst-read bus (master side)
//   line_o, line_ack_o         assembled line and its one-cycle valid pulse
//   line_err_o                 one-cycle pulse: fill aborted by bus error
//   cword_o, cword_vld_o       critical word and its one-cycle valid pulse
module riscv_cache_biu_fill #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PLEN     = 32,
  parameter int unsigned BLK_BITS = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fill_req_i,
  input  logic [PLEN-1:0]               fill_adr_i,
  output logic                          fill_busy_o,
  riscv_cache_biu_fill_if.master        biu,
  output logic [BLK_BITS-1:0]           line_o,
  output logic                          line_ack_o,
  output logic                          line_err_o,
  output logic [XLEN-1:0]               cword_o,
  output logic                          cword_vld_o
);

  localparam int unsigned BEATS = BLK_BITS / XLEN;
  localparam int unsigned OffW  = $clog2(XLEN / 8);
  // Keep index/count at least one bit wide so BEATS=1 still elaborates.
  localparam int unsigned IdxW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [PLEN-1:0] AdrMask = PLEN'((64'd1 << OffW) - 64'd1);
  localparam logic [IdxW-1:0] LastCnt = IdxW'(BEATS - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [PLEN-1:0]     adr_q, adr_d;
  logic [IdxW-1:0]     widx_q, widx_d;
  logic [IdxW-1:0]     cnt_q, cnt_d;
  logic [BLK_BITS-1:0] line_q, line_d;
  logic [XLEN-1:0]     cword_q, cword_d;
  logic                cword_vld_q, cword_vld_d;
  logic                beat;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    widx_d      = widx_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    cword_d     = cword_q;
    cword_vld_d = 1'b0;
    beat        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fill_req_i) begin
          state_d = StAddr;
          adr_d   = fill_adr_i & ~AdrMask;
          widx_d  = (BEATS > 1) ? fill_adr_i[OffW +: IdxW] : '0;
          cnt_d   = '0;
        end
      end
      StAddr: begin
        if (biu.biu_err) begin
          state_d = StErr;
        end else if (biu.biu_ack) begin
          state_d = StData;
          // Data may already arrive alongside the address acknowledge.
          beat    = biu.biu_d_ack;
        end
      end
      StData: begin
        if (biu.biu_err) begin
          state_d = StErr;
        end else begin
          beat = biu.biu_d_ack;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (beat) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (widx_q == IdxW'(i)) line_d[i*XLEN +: XLEN] = biu.biu_d;
      end
      widx_d = (BEATS > 1) ? widx_q + 1'b1 : '0;
      if (cnt_q == '0) begin
        cword_d     = biu.biu_d;
        cword_vld_d = 1'b1;
      end
      if (cnt_q == LastCnt) begin
        cnt_d   = '0;
        state_d = StDone;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      widx_q      <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      cword_q     <= '0;
      cword_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      widx_q      <= widx_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      cword_q     <= cword_d;
      cword_vld_q <= cword_vld_d;
    end
  end

  // Every output is a decode of registered state only.
  assign fill_busy_o = (state_q != StIdle);
  assign biu.biu_req = (state_q == StAddr);
  assign biu.biu_adr = adr_q;
  assign biu.biu_len = (state_q == StAddr) ? 8'(BEATS - 1) : 8'd0;
  assign line_o      = line_q;
  assign line_ack_o  = (state_q == StDone);
  assign line_err_o  = (state_q == StErr);
  assign cword_o     = cword_q;
  assign cword_vld_o = cword_vld_q;

endmodule

// File: tb/tb_riscv_cache_biu_fill.sv
module tb_riscv_cache_biu_fill;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 32-bit beats, 128-bit line (4 beats)
  logic         fill_req_a, busy_a, line_ack_a, line_err_a, cword_vld_a;
  logic [31:0]  fill_adr_a, cword_a;
  logic [127:0] line_a;
  // DUT B: single-beat line
  logic         fill_req_b, busy_b, line_ack_b, line_err_b, cword_vld_b;
  logic [31:0]  fill_adr_b, cword_b, line_b;

  riscv_cache_biu_fill_if #(.XLEN(32), .PLEN(32)) bus_a ();
  riscv_cache_biu_fill_if #(.XLEN(32), .PLEN(32)) bus_b ();

  riscv_cache_biu_fill #(.XLEN(32), .PLEN(32), .BLK_BITS(128)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .fill_req_i(fill_req_a), .fill_adr_i(fill_adr_a),
    .fill_busy_o(busy_a), .biu(bus_a.master), .line_o(line_a), .line_ack_o(line_ack_a),
    .line_err_o(line_err_a), .cword_o(cword_a), .cword_vld_o(cword_vld_a)
  );

  riscv_cache_biu_fill #(.XLEN(32), .PLEN(32), .BLK_BITS(32)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .fill_req_i(fill_req_b), .fill_adr_i(fill_adr_b),
    .fill_busy_o(busy_b), .biu(bus_b.master), .line_o(line_b), .line_ack_o(line_ack_b),
    .line_err_o(line_err_b), .cword_o(cword_b), .cword_vld_o(cword_vld_b)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then settled and inputs
  // set afterwards apply to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input string tag, input logic [31:0] adr, input int ack_dly,
                         input int waits, input bit d_on_ack, input bit req_busy,
                         input logic [31:0] d0, input logic [127:0] exp_line,
                         input logic [31:0] exp_cword);
    int first;
    fill_req_a = 1'b1;
    fill_adr_a = adr;
    tick();
    fill_req_a = 1'b0;
    check_eq({tag, ".req"}, 128'(bus_a.biu_req), 128'd1);
    check_eq({tag, ".adr"}, 128'(bus_a.biu_adr), 128'(adr & ~32'h3));
    check_eq({tag, ".len"}, 128'(bus_a.biu_len), 128'd3);
    for (int i = 0; i < ack_dly; i++) begin
      if (req_busy) begin
        fill_req_a = 1'b1;
        fill_adr_a = 32'h3000;
      end
      tick();
      fill_req_a = 1'b0;
      check_eq({tag, ".req_hold"}, 128'(bus_a.biu_req), 128'd1);
      check_eq({tag, ".adr_hold"}, 128'(bus_a.biu_adr), 128'(adr & ~32'h3));
    end
    bus_a.biu_ack = 1'b1;
    first = 0;
    if (d_on_ack) begin
      bus_a.biu_d_ack = 1'b1;
      bus_a.biu_d     = d0;
      first           = 1;
    end
    tick();
    bus_a.biu_ack   = 1'b0;
    bus_a.biu_d_ack = 1'b0;
    if (d_on_ack) begin
      check_eq({tag, ".cvld_ack"}, 128'(cword_vld_a), 128'd1);
      check_eq({tag, ".cword_ack"}, 128'(cword_a), 128'(exp_cword));
    end
    for (int b = first; b < 4; b++) begin
      for (int w = 0; w < waits; w++) begin
        tick();
        check_eq({tag, ".wait_ack"}, 128'(line_ack_a), 128'd0);
        check_eq({tag, ".wait_cvld"}, 128'(cword_vld_a), 128'd0);
      end
      bus_a.biu_d_ack = 1'b1;
      bus_a.biu_d     = d0 + 32'(b);
      tick();
      bus_a.biu_d_ack = 1'b0;
      if (b == 0) begin
        check_eq({tag, ".cvld"}, 128'(cword_vld_a), 128'd1);
        check_eq({tag, ".cword"}, 128'(cword_a), 128'(exp_cword));
      end
      if (b < 3) check_eq({tag, ".early_ack"}, 128'(line_ack_a), 128'd0);
    end
    check_eq({tag, ".line_ack"}, 128'(line_ack_a), 128'd1);
    check_eq({tag, ".line"}, line_a, exp_line);
    check_eq({tag, ".busy_done"}, 128'(busy_a), 128'd1);
    tick();
    check_eq({tag, ".ack_off"}, 128'(line_ack_a), 128'd0);
    check_eq({tag, ".idle"}, 128'(busy_a), 128'd0);
    tick();
    check_eq({tag, ".no_req"}, 128'(bus_a.biu_req), 128'd0);
  endtask

  initial begin
    rst        = 1'b1;
    fill_req_a = 1'b0;
    fill_adr_a = '0;
    fill_req_b = 1'b0;
    fill_adr_b = '0;
    bus_a.biu_ack = 1'b0; bus_a.biu_d = '0; bus_a.biu_d_ack = 1'b0; bus_a.biu_err = 1'b0;
    bus_b.biu_ack = 1'b0; bus_b.biu_d = '0; bus_b.biu_d_ack = 1'b0; bus_b.biu_err = 1'b0;

    // Reset state
    tick();
    check_eq("rst.busy", 128'(busy_a), 128'd0);
    check_eq("rst.req", 128'(bus_a.biu_req), 128'd0);
    check_eq("rst.adr", 128'(bus_a.biu_adr), 128'd0);
    check_eq("rst.len", 128'(bus_a.biu_len), 128'd0);
    check_eq("rst.line", line_a, 128'd0);
    check_eq("rst.cword", 128'(cword_a), 128'd0);
    check_eq("rst.b_busy", 128'(busy_b), 128'd0);
    tick();
    rst = 1'b0;

    // 1: plain wrapping fill from word 2
    do_fill("t1", 32'h1008, 0, 0, 1'b0, 1'b0, 32'hA0,
            128'h000000A1_000000A0_000000A3_000000A2, 32'hA0);

    // 2: same fill with address-phase delay and data wait states
    do_fill("t2", 32'h1008, 3, 2, 1'b0, 1'b0, 32'hA0,
            128'h000000A1_000000A0_000000A3_000000A2, 32'hA0);

    // 3: bus error together with beat 2
    fill_req_a = 1'b1; fill_adr_a = 32'h1008;
    tick();
    fill_req_a = 1'b0; bus_a.biu_ack = 1'b1;
    tick();
    bus_a.biu_ack = 1'b0; bus_a.biu_d_ack = 1'b1; bus_a.biu_d = 32'hC0;
    tick();
    bus_a.biu_d = 32'hC1;
    tick();
    bus_a.biu_d = 32'hC2; bus_a.biu_err = 1'b1;
    tick();
    bus_a.biu_d_ack = 1'b0; bus_a.biu_err = 1'b0;
    check_eq("t3.err", 128'(line_err_a), 128'd1);
    check_eq("t3.no_ack", 128'(line_ack_a), 128'd0);
    check_eq("t3.busy_err", 128'(busy_a), 128'd1);
    tick();
    check_eq("t3.err_off", 128'(line_err_a), 128'd0);
    check_eq("t3.idle", 128'(busy_a), 128'd0);
    check_eq("t3.no_ack2", 128'(line_ack_a), 128'd0);
    bus_a.biu_err = 1'b1;   // stray error while idle
    tick();
    bus_a.biu_err = 1'b0;
    check_eq("t3.idle_err", 128'(line_err_a), 128'd0);
    do_fill("t3b", 32'h1008, 0, 0, 1'b0, 1'b0, 32'hB0,
            128'h000000B1_000000B0_000000B3_000000B2, 32'hB0);

    // 4: reset after two beats
    fill_req_a = 1'b1; fill_adr_a = 32'h2000;
    tick();
    fill_req_a = 1'b0; bus_a.biu_ack = 1'b1;
    tick();
    bus_a.biu_ack = 1'b0; bus_a.biu_d_ack = 1'b1; bus_a.biu_d = 32'hC0;
    tick();
    bus_a.biu_d = 32'hC1;
    tick();
    rst = 1'b1; bus_a.biu_d = 32'hC2;
    tick();
    rst = 1'b0;
    check_eq("t4.busy", 128'(busy_a), 128'd0);
    check_eq("t4.req", 128'(bus_a.biu_req), 128'd0);
    check_eq("t4.line", line_a, 128'd0);
    check_eq("t4.cword", 128'(cword_a), 128'd0);
    check_eq("t4.ack", 128'(line_ack_a), 128'd0);
    check_eq("t4.err", 128'(line_err_a), 128'd0);
    bus_a.biu_d = 32'hC3;
    tick();
    bus_a.biu_d_ack = 1'b0;
    tick();
    check_eq("t4.ign_busy", 128'(busy_a), 128'd0);
    check_eq("t4.ign_line", line_a, 128'd0);
    check_eq("t4.ign_cvld", 128'(cword_vld_a), 128'd0);
    do_fill("t4b", 32'h2000, 0, 0, 1'b0, 1'b0, 32'hD0,
            128'h000000D3_000000D2_000000D1_000000D0, 32'hD0);

    // 5: request while busy is ignored; beat 0 arrives with the address ack
    do_fill("t5", 32'h100C, 1, 0, 1'b1, 1'b1, 32'hE0,
            128'h000000E0_000000E3_000000E2_000000E1, 32'hE0);

    // 6: single-beat line
    fill_req_b = 1'b1; fill_adr_b = 32'h44;
    tick();
    fill_req_b = 1'b0;
    check_eq("t6.req", 128'(bus_b.biu_req), 128'd1);
    check_eq("t6.adr", 128'(bus_b.biu_adr), 128'h44);
    check_eq("t6.len", 128'(bus_b.biu_len), 128'd0);
    bus_b.biu_ack = 1'b1; bus_b.biu_d_ack = 1'b1; bus_b.biu_d = 32'h5A5A0044;
    tick();
    bus_b.biu_ack = 1'b0; bus_b.biu_d_ack = 1'b0;
    check_eq("t6.cvld", 128'(cword_vld_b), 128'd1);
    check_eq("t6.ack", 128'(line_ack_b), 128'd1);
    check_eq("t6.line", 128'(line_b), 128'h5A5A0044);
    check_eq("t6.cword", 128'(cword_b), 128'h5A5A0044);
    tick();
    check_eq("t6.idle", 128'(busy_b), 128'd0);
    check_eq("t6.ack_off", 128'(line_ack_b), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
